// File: rtl/mem_req_responder.sv
// mem_req_responder: single-outstanding valid/ready memory responder with programmable wait states,
// little-endian byte/half/word lanes and misaligned/out-of-range error reporting.
module mem_req_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 2);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [1:0]        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [IW-1:0] idx;
    logic [31:0] word, lane, mask, rd_sh, wmerge;
    logic [4:0]  bsh;
    logic        mis, oor, we;
    logic [1:0]  err;

    // Lane arithmetic works on the shifted word so byte, half and word share one datapath.
    always_comb begin
        idx    = addr_q[IW+1:2];
        word   = mem[idx];
        bsh    = {addr_q[1:0], 3'b000};
        mis    = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
        oor    = addr_q >= ADDR_W'(4 * DEPTH_WORDS);
        err    = mis ? 2'b01 : oor ? 2'b10 : 2'b00;
        lane   = size_q == 2'b00 ? 32'h0000_00ff : size_q == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff;
        mask   = lane << bsh;
        rd_sh  = (word >> bsh) & lane;
        wmerge = (word & ~mask) | ((wdata_q << bsh) & mask);
        we     = (state_q == S_ACCESS) && wr_q && (err == 2'b00);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: if (req_valid && req_ready_q) begin
                addr_d  = req_addr;
                wr_d    = req_wr;
                size_d  = req_size;
                wdata_d = req_wdata;
                cnt_d   = CW'(WAIT_CYCLES);
                state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? S_ACCESS : S_WAIT;
            end
            S_ACCESS: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = (wr_q || err != 2'b00) ? 32'h0 : rd_sh;
                resp_err_d   = err;
            end
            default: if (resp_ready) begin
                resp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            wdata_q      <= 32'h0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage is never reset; state_q sits in IDLE during reset so no write can slip through.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wmerge;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
endmodule
